// File: rtl/vid_pattern_gen_pkg.sv
// Shared definitions for the video pattern generator.
//   vstate_t   : vertical raster state (idle, sync, back porch, active, front porch)
//   pattern_t  : pattern_sel codes
//   LFSR_SEED  : noise LFSR seed, reloaded at every frame start
//   LFSR_TAPS  : feedback mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
package vid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_BACK,
    ST_ACTIVE,
    ST_FRONT
  } vstate_t;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_FLAT    = 2'd3
  } pattern_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/vid_pattern_gen_if.sv
// Video stream bundle consumed by the filter chain.
//   vs         : vertical sync
//   de         : active pixel valid
//   data       : 8-bit pixel, zero outside de
//   frame_done : one-cycle pulse on the last blank cycle of a frame
// master = pattern source, slave = filter / monitor.
interface vid_pattern_gen_if;
  logic       vs;
  logic       de;
  logic [7:0] data;
  logic       frame_done;

  modport master (output vs, de, data, frame_done);
  modport slave  (input  vs, de, data, frame_done);
endinterface

// File: rtl/vid_pattern_gen_lfsr16.sv
// 16-bit Fibonacci LFSR used as the salt-and-pepper noise source.
//   clk, rst_n : clock, synchronous active-low reset (reloads the seed)
//   load       : reload LFSR_SEED (wins over step)
//   step       : advance one position
//   q          : current LFSR state
module lfsr16
  import vid_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [15:0] q
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous, so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      q <= LFSR_SEED;
    end else if (step) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/vid_pattern_gen.sv
// Camera stand-in: full raster timing, selectable test patterns and optional
// salt-and-pepper noise on a vs/de/data stream.
//   clk, rst_n  : pixel clock, synchronous active-low reset
//   en          : run enable; a frame starts only while en=1, and a started
//                 frame always runs to completion
//   pattern_sel : 0 h-ramp, 1 v-ramp, 2 8x8 checker, 3 flat 128 (latched per frame)
//   noise_en    : salt-and-pepper injection enable (latched per frame)
//   vid         : vs/de/data/frame_done stream, all outputs registered
module vid_pattern_gen
  import vid_pkg::*;
#(
  parameter int COL      = 640,
  parameter int ROW      = 480,
  parameter int H_BACK   = 48,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_FRONT  = 10,
  parameter int NOISE_TH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           pattern_sel,
  input  logic                 noise_en,
  vid_pattern_gen_if.master    vid
);

  localparam int H_TOTAL = H_BACK + COL + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + ROW + V_FRONT;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] ACT_FIRST = HW'(H_BACK);
  localparam logic [HW-1:0] ACT_LAST  = HW'(H_BACK + COL - 1);

  // Empty back porch is skipped straight into the active region.
  localparam vstate_t AFTER_SYNC = (V_BACK > 0) ? ST_BACK : ST_ACTIVE;

  vstate_t       state, next_state;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vline, state_last;
  pattern_t      pat_q;
  logic          noise_q;
  logic          vs_q, de_q, frame_done_q;
  logic [7:0]    data_q, pix;
  logic [15:0]   lfsr_q;
  logic [15:0]   x_pos, y_pos;
  logic          line_end, state_done, frame_end, enter_sync, active, noise_hit;

  assign line_end = (hcnt == H_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    state_last = '0;
    unique case (state)
      ST_SYNC:   state_last = VW'(V_SYNC - 1);
      ST_BACK:   state_last = VW'(V_BACK - 1);
      ST_ACTIVE: state_last = VW'(ROW - 1);
      ST_FRONT:  state_last = VW'(V_FRONT - 1);
      default:   state_last = '0;
    endcase
  end

  assign state_done = line_end && (vline == state_last);
  // With an empty front porch the frame ends with the last active line.
  assign frame_end  = state_done &&
                      ((state == ST_FRONT) || ((state == ST_ACTIVE) && (V_FRONT == 0)));

  always_comb begin
    next_state = state;
    if (state == ST_IDLE) begin
      if (en) next_state = ST_SYNC;
    end else if (state_done) begin
      unique case (state)
        ST_SYNC:   next_state = AFTER_SYNC;
        ST_BACK:   next_state = ST_ACTIVE;
        ST_ACTIVE: next_state = (V_FRONT > 0) ? ST_FRONT : (en ? ST_SYNC : ST_IDLE);
        ST_FRONT:  next_state = en ? ST_SYNC : ST_IDLE;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  assign enter_sync = (next_state == ST_SYNC) && (state != ST_SYNC);
  assign active     = (state == ST_ACTIVE) && (hcnt >= ACT_FIRST) && (hcnt <= ACT_LAST);

  // Pattern coordinates; vline is the active line index while in ACTIVE.
  assign x_pos = 16'(hcnt) - 16'(H_BACK);
  assign y_pos = 16'(vline);

  assign noise_hit = noise_q && ({1'b0, lfsr_q[7:0]} < 9'(NOISE_TH));

  always_comb begin
    pix = 8'd0;
    unique case (pat_q)
      PAT_HRAMP:   pix = x_pos[7:0];
      PAT_VRAMP:   pix = y_pos[7:0];
      PAT_CHECKER: pix = (x_pos[3] ^ y_pos[3]) ? 8'd255 : 8'd0;
      PAT_FLAT:    pix = 8'd128;
      default:     pix = 8'd0;
    endcase
    if (noise_hit) pix = lfsr_q[8] ? 8'd255 : 8'd0;
  end

  // Reseeded at each frame start so identical settings give identical frames;
  // advances once per emitted pixel.
  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (enter_sync),
    .step  (active),
    .q     (lfsr_q)
  );

  // Raster FSM with registered outputs: outputs trail the state by one cycle,
  // uniformly, so vs/de/data/frame_done stay mutually aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      hcnt         <= '0;
      vline        <= '0;
      pat_q        <= PAT_HRAMP;
      noise_q      <= 1'b0;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      data_q       <= 8'd0;
      frame_done_q <= 1'b0;
    end else begin
      state <= next_state;
      hcnt  <= (state == ST_IDLE || line_end) ? '0 : hcnt + 1'b1;
      if (state == ST_IDLE || state_done) begin
        vline <= '0;
      end else if (line_end) begin
        vline <= vline + 1'b1;
      end
      if (enter_sync) begin
        pat_q   <= pattern_t'(pattern_sel);
        noise_q <= noise_en;
      end
      vs_q         <= (state == ST_SYNC);
      de_q         <= active;
      data_q       <= active ? pix : 8'd0;
      frame_done_q <= frame_end;
    end
  end

  assign vid.vs         = vs_q;
  assign vid.de         = de_q;
  assign vid.data       = data_q;
  assign vid.frame_done = frame_done_q;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench for vid_pattern_gen. Instance A: 8x4 active, 12x7 raster
// (84-cycle frames), no noise threshold. Instance B: 16x16 active, 20x19
// raster (380-cycle frames), NOISE_TH=64. Capture index 0 is the first vs=1
// cycle of a frame; line = index/H_TOTAL, line 0 = sync, 1 = back porch.
module tb_vid_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, en_a, noise_a;
  logic [1:0] sel_a;
  logic       rst_n_b, en_b, noise_b;
  logic [1:0] sel_b;

  vid_pattern_gen_if va ();
  vid_pattern_gen_if vb ();

  vid_pattern_gen #(
    .COL(8), .ROW(4), .H_BACK(2), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .NOISE_TH(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n_a), .en(en_a), .pattern_sel(sel_a),
    .noise_en(noise_a), .vid(va)
  );

  vid_pattern_gen #(
    .COL(16), .ROW(16), .H_BACK(2), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .NOISE_TH(64)
  ) u_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b), .pattern_sel(sel_b),
    .noise_en(noise_b), .vid(vb)
  );

  bit         mon_b = 1'b0;
  logic       m_vs, m_de, m_fd;
  logic [7:0] m_data;
  assign m_vs   = mon_b ? vb.vs         : va.vs;
  assign m_de   = mon_b ? vb.de         : va.de;
  assign m_fd   = mon_b ? vb.frame_done : va.frame_done;
  assign m_data = mon_b ? vb.data       : va.data;

  logic       c_vs [0:1023];
  logic       c_de [0:1023];
  logic       c_fd [0:1023];
  logic [7:0] c_data [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic wait_vs_rise(input string tag);
    logic prev;
    bit   found;
    found = 1'b0;
    prev  = m_vs;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (!prev && m_vs) found = 1'b1;
      prev = m_vs;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s_vs_timeout: got no vs rise, required one within 2000 cycles", tag);
    end
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      c_vs[i] = m_vs; c_de[i] = m_de; c_fd[i] = m_fd; c_data[i] = m_data;
    end
  endtask

  function automatic logic [7:0] exp_pix(input int mode, input int x, input int y);
    logic [7:0] r;
    case (mode)
      0:       r = x[7:0];
      1:       r = y[7:0];
      2:       r = (x[3] ^ y[3]) ? 8'd255 : 8'd0;
      default: r = 8'd128;
    endcase
    return r;
  endfunction

  // Mismatch count of vs/de/data/frame_done against the raster model over
  // len cycles (V_SYNC=V_BACK=V_FRONT=1 on both instances).
  function automatic int frame_errs(input int len, input int htot, input int hb,
                                    input int col, input int rows, input int mode);
    int   errs, fl, k2, line, h;
    logic act, ev, ef;
    logic [7:0] ed;
    errs = 0;
    fl   = htot * (rows + 3);
    for (int k = 0; k < len; k++) begin
      k2   = k % fl;
      line = k2 / htot;
      h    = k2 % htot;
      act  = (line >= 2) && (line < 2 + rows) && (h >= hb) && (h < hb + col);
      ed   = act ? exp_pix(mode, h - hb, line - 2) : 8'd0;
      ev   = (line == 0);
      ef   = (k2 == fl - 1);
      if (c_de[k] !== act || c_data[k] !== ed || c_vs[k] !== ev || c_fd[k] !== ef) errs++;
    end
    return errs;
  endfunction

  task automatic test_reset;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    en_a = 1'b0; en_b = 1'b0; sel_a = 2'd0; sel_b = 2'd0; noise_a = 1'b0; noise_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({va.vs, va.de, va.data, va.frame_done} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_a: got %b required 0", {va.vs, va.de, va.data, va.frame_done});
    end
    n_checks++;
    if ({vb.vs, vb.de, vb.data, vb.frame_done} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_b: got %b required 0", {vb.vs, vb.de, vb.data, vb.frame_done});
    end
    rst_n_b = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if ({vb.vs, vb.de} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_no_en: got vs/de %b required 00", {vb.vs, vb.de});
    end
  endtask

  task automatic test_timing;
    int vs_run, vs_cnt, de_first, de_cnt, bursts, fd0, fd1, errs;
    mon_b = 1'b0; sel_a = 2'd0; noise_a = 1'b1; en_a = 1'b1;
    rst_n_a = 1'b1;
    wait_vs_rise("timing");
    capture(169);
    vs_run = 0; vs_cnt = 0; de_first = -1; de_cnt = 0; bursts = 0; fd0 = -1; fd1 = -1;
    while (vs_run < 84 && c_vs[vs_run] === 1'b1) vs_run++;
    for (int k = 0; k < 84; k++) begin
      if (c_vs[k] === 1'b1) vs_cnt++;
      if (c_de[k] === 1'b1) begin
        de_cnt++;
        if (de_first < 0) de_first = k;
        if (k == 0 || c_de[k-1] !== 1'b1) bursts++;
      end
    end
    for (int k = 0; k < 169; k++)
      if (c_fd[k] === 1'b1) begin
        if (fd0 < 0) fd0 = k; else if (fd1 < 0) fd1 = k;
      end
    n_checks++; if (vs_run !== 12 || vs_cnt !== 12) begin n_fail++;
      $display("FAIL vs_width: got run %0d total %0d required 12", vs_run, vs_cnt); end
    n_checks++; if (de_first !== 26) begin n_fail++;
      $display("FAIL de_first: got %0d required 26", de_first); end
    n_checks++; if (de_cnt !== 32) begin n_fail++;
      $display("FAIL de_count: got %0d required 32", de_cnt); end
    n_checks++; if (bursts !== 4) begin n_fail++;
      $display("FAIL de_bursts: got %0d required 4", bursts); end
    n_checks++; if (fd0 !== 83) begin n_fail++;
      $display("FAIL fd_pos: got %0d required 83", fd0); end
    n_checks++; if (fd1 - fd0 !== 84) begin n_fail++;
      $display("FAIL fd_period: got %0d required 84", fd1 - fd0); end
    n_checks++; if (c_vs[83] !== 1'b0 || c_vs[84] !== 1'b1) begin n_fail++;
      $display("FAIL frame_period: got vs[83..84]=%b%b required 01", c_vs[83], c_vs[84]); end
    errs = frame_errs(168, 12, 2, 8, 4, 0);
    n_checks++; if (errs !== 0) begin n_fail++;
      $display("FAIL hramp_th0: got %0d bad cycles required 0", errs); end
    n_checks++; if (c_data[28] !== 8'd2 || c_data[33] !== 8'd7) begin n_fail++;
      $display("FAIL hramp_points: got %0d,%0d required 2,7", c_data[28], c_data[33]); end
  endtask

  task automatic test_pattern_change;
    int errs;
    wait_vs_rise("pchg");
    fork
      capture(84);
      begin repeat (40) @(negedge clk); sel_a = 2'd1; end
    join
    errs = frame_errs(84, 12, 2, 8, 4, 0);
    n_checks++; if (errs !== 0) begin n_fail++;
      $display("FAIL sel_held: got %0d bad cycles required 0", errs); end
    wait_vs_rise("vramp");
    capture(84);
    errs = frame_errs(84, 12, 2, 8, 4, 1);
    n_checks++; if (errs !== 0) begin n_fail++;
      $display("FAIL vramp: got %0d bad cycles required 0", errs); end
    n_checks++; if (c_data[41] !== 8'd1 || c_data[69] !== 8'd3) begin n_fail++;
      $display("FAIL vramp_points: got %0d,%0d required 1,3", c_data[41], c_data[69]); end
  endtask

  task automatic test_en_drop;
    int de_cnt, tail, errs;
    wait_vs_rise("endrop");
    fork
      capture(108);
      begin repeat (40) @(negedge clk); en_a = 1'b0; end
    join
    de_cnt = 0; tail = 0;
    for (int k = 0; k < 84; k++) if (c_de[k] === 1'b1) de_cnt++;
    for (int k = 84; k < 108; k++) if (c_vs[k] !== 1'b0 || c_de[k] !== 1'b0) tail++;
    errs = frame_errs(84, 12, 2, 8, 4, 1);
    n_checks++; if (de_cnt !== 32 || errs !== 0) begin n_fail++;
      $display("FAIL endrop_frame: got de %0d bad %0d required 32 and 0", de_cnt, errs); end
    n_checks++; if (tail !== 0) begin n_fail++;
      $display("FAIL endrop_idle: got %0d active cycles after frame required 0", tail); end
  endtask

  task automatic test_reset_mid;
    int errs;
    en_a = 1'b1;
    wait_vs_rise("rstmid");
    repeat (40) @(negedge clk);
    n_checks++; if (va.de !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_pre: got de %b required 1", va.de); end
    rst_n_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({va.vs, va.de, va.data, va.frame_done} !== 11'd0) begin n_fail++;
      $display("FAIL rstmid_clear: got %b required 0", {va.vs, va.de, va.data, va.frame_done}); end
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;
    wait_vs_rise("rstmid_post");
    capture(84);
    errs = frame_errs(84, 12, 2, 8, 4, 1);
    n_checks++; if (errs !== 0) begin n_fail++;
      $display("FAIL rstmid_frame: got %0d bad cycles required 0", errs); end
    en_a = 1'b0;
  endtask

  task automatic run_b(input logic [1:0] sel, input logic nz, input int n, input int drop_at);
    mon_b = 1'b1; sel_b = sel; noise_b = nz; en_b = 1'b1;
    wait_vs_rise("run_b");
    fork
      capture(n);
      begin repeat (drop_at) @(negedge clk); en_b = 1'b0; end
    join
  endtask

  task automatic test_checker_flat;
    int errs;
    run_b(2'd2, 1'b0, 380, 10);
    errs = frame_errs(380, 20, 2, 16, 16, 2);
    n_checks++; if (errs !== 0) begin n_fail++;
      $display("FAIL checker: got %0d bad cycles required 0", errs); end
    n_checks++;
    if (c_data[42] !== 8'd0 || c_data[50] !== 8'd255 || c_data[202] !== 8'd255 || c_data[210] !== 8'd0) begin
      n_fail++;
      $display("FAIL checker_points: got %0d,%0d,%0d,%0d required 0,255,255,0",
               c_data[42], c_data[50], c_data[202], c_data[210]);
    end
    run_b(2'd3, 1'b0, 381, 10);
    errs = frame_errs(380, 20, 2, 16, 16, 3);
    n_checks++; if (errs !== 0) begin n_fail++;
      $display("FAIL flat: got %0d bad cycles required 0", errs); end
    n_checks++; if (c_data[42] !== 8'd128 || c_data[41] !== 8'd0 || c_vs[380] !== 1'b0) begin n_fail++;
      $display("FAIL flat_points: got %0d,%0d vs %b required 128,0 vs 0", c_data[42], c_data[41], c_vs[380]); end
  endtask

  task automatic test_noise;
    logic [15:0] lfsr;
    logic [7:0]  ed, clean;
    logic        act;
    int line, h, errs, diff_frames, model_diff, dut_diff, bad_val;
    run_b(2'd0, 1'b1, 760, 400);
    diff_frames = 0;
    for (int k = 0; k < 380; k++)
      if (c_de[k] !== c_de[k+380] || c_data[k] !== c_data[k+380] || c_vs[k] !== c_vs[k+380]) diff_frames++;
    n_checks++; if (diff_frames !== 0) begin n_fail++;
      $display("FAIL noise_repeat: got %0d differing cycles required 0", diff_frames); end
    lfsr = 16'hACE1; errs = 0; model_diff = 0; dut_diff = 0; bad_val = 0;
    for (int k = 0; k < 380; k++) begin
      line  = k / 20; h = k % 20;
      act   = (line >= 2) && (line < 18) && (h >= 2) && (h < 18);
      clean = act ? 8'(h - 2) : 8'd0;
      ed    = clean;
      if (act) begin
        if (lfsr[7:0] < 8'd64) begin
          ed = lfsr[8] ? 8'd255 : 8'd0;
          if (ed != clean) model_diff++;
        end
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (c_data[k] !== clean) begin
          dut_diff++;
          if (c_data[k] !== 8'd0 && c_data[k] !== 8'd255) bad_val++;
        end
      end
      if (c_de[k] !== act || c_data[k] !== ed) errs++;
    end
    n_checks++; if (errs !== 0) begin n_fail++;
      $display("FAIL noise_model: got %0d bad cycles required 0", errs); end
    n_checks++; if (dut_diff !== model_diff) begin n_fail++;
      $display("FAIL noise_count: got %0d replaced required %0d", dut_diff, model_diff); end
    n_checks++; if (bad_val !== 0) begin n_fail++;
      $display("FAIL noise_values: got %0d non 0/255 replacements required 0", bad_val); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_pattern_change();
    test_en_drop();
    test_reset_mid();
    test_checker_flat();
    test_noise();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vid_pattern_gen.md
Name: vid_pattern_gen

Overview:
Frame source that drives the vs/de/8-bit-data video stream consumed by the filter chain (median, matrix, move_center). It produces full raster timing (vertical sync, back porch, active, front porch), selectable test patterns, and optional salt-and-pepper noise injection. Used as a camera stand-in for bring-up and for closed-loop verification of the filters.

Parameters:
COL, 640, active pixels per line
ROW, 480, active lines per frame
H_BACK, 48, blank cycles before the active pixels in each line
H_FRONT, 16, blank cycles after the active pixels in each line
V_SYNC, 2, lines with vs=1 at frame start
V_BACK, 33, blank lines after sync
V_FRONT, 10, blank lines after the active region
NOISE_TH, 8, noise probability threshold; a pixel is replaced when lfsr[7:0] < NOISE_TH

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset; synchronous, active-low; clock clk
en  in  1  run enable; frames start only while en=1
pattern_sel  in  2  0 = horizontal ramp, 1 = vertical ramp, 2 = 8x8 checker, 3 = flat 128
noise_en  in  1  enable salt-and-pepper injection
vs  out  1  vertical sync, high for the V_SYNC lines
de  out  1  active pixel valid
data  out  8  pixel value; 0 whenever de=0
frame_done  out  1  one-cycle pulse on the last cycle of the V_FRONT region

Behaviour:
- Derived constants: H_TOTAL = H_BACK+COL+H_FRONT; V_TOTAL = V_SYNC+V_BACK+ROW+V_FRONT.
- Counters: hcnt runs 0..H_TOTAL-1 and wraps; vline is the line index within the current vertical state. x = hcnt-H_BACK; y = active line index 0..ROW-1.
- Vertical FSM states: IDLE, SYNC, BACK, ACTIVE, FRONT.
  - IDLE -> SYNC when en=1. hcnt=0 on the first SYNC cycle.
  - SYNC -> BACK after V_SYNC lines.
  - BACK -> ACTIVE after V_BACK lines.
  - ACTIVE -> FRONT after ROW lines.
  - FRONT -> SYNC if en=1, otherwise IDLE, after V_FRONT lines.
  - Each transition happens at the hcnt wrap.
- Zero-length porch parameters skip the corresponding state.
- All outputs are registered. vs, de and data change together; data is valid in the same cycle de=1.
- vs=1 for every cycle of SYNC, so it is high for V_SYNC*H_TOTAL consecutive cycles.
- de=1 only in ACTIVE with hcnt in [H_BACK, H_BACK+COL-1]. That gives exactly COL de cycles per line and COL*ROW per frame.
- Frame-boundary sampling:
  - pattern_sel and noise_en are sampled on entry to SYNC and held for the whole frame.
  - Deasserting en mid-frame lets the current frame complete; truncated frames are never produced.
- Pattern values:
  - Ramp: data = x[7:0] or y[7:0] (mod 256).
  - Checker: data = (x[3]^y[3]) ? 255 : 0.
  - Flat: data = 128.
- Noise LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1.
  - Reseeded on SYNC entry, so identical settings give identical frames.
  - Advances once per de=1 cycle only.
  - When the latched noise_en=1 and lfsr[7:0] < NOISE_TH, the pixel becomes lfsr[8] ? 255 : 0.
  - NOISE_TH=0 means no injection.
- frame_done pulses when FRONT ends; the pulse occurs even if the next frame follows immediately.
- Reset, including mid-frame: the next cycle has vs=0, de=0, data=0, frame_done=0, state IDLE, counters 0 and the LFSR reseeded. A new frame starts with a full SYNC.
- en=1 held continuously: frames are back-to-back with a period of exactly V_TOTAL*H_TOTAL cycles, with no idle gap.

Decomposition:
- Package vid_pkg holds:
  - the vertical state enum (IDLE/SYNC/BACK/ACTIVE/FRONT);
  - the pattern_sel code constants;
  - LFSR_SEED = 16'hACE1 and the tap mask.
- Sub-module lfsr16: inputs clk, rst_n, load, step; output q[15:0]. Instantiated once; load is driven on SYNC entry and step is driven by de.

Test Plan:
- Timing (COL=8, ROW=4, H_BACK=2, H_FRONT=2, V_SYNC=1, V_BACK=1, V_FRONT=1), en=1 from reset release. Required:
  - vs high for 12 cycles;
  - de rises 2+12*2=26 cycles after SYNC entry;
  - 32 de cycles per frame, in 4 bursts of 8;
  - frame_done every 84 cycles.
- Horizontal ramp, same parameters, pattern_sel=0 -> each active line yields 0,1,...,7. Vertical ramp, pattern_sel=1 -> lines yield all-0, all-1, all-2, all-3.
- Checker (COL=16, ROW=16), pattern_sel=2 -> lines 0-7 show 8×0 then 8×255; lines 8-15 are inverted. Flat (pattern_sel=3) -> every de pixel is 128, and data=0 whenever de=0.
- Noise:
  - NOISE_TH=0, noise_en=1 -> output matches the clean ramp exactly.
  - NOISE_TH=64 -> two consecutive frames are bit-identical, and every replaced pixel is 0 or 255.
  - The replaced-pixel count matches a reference LFSR model.
- en dropped mid-ACTIVE -> the frame finishes with all 32 de cycles, then IDLE (vs=de=0). pattern_sel changed mid-frame -> takes effect only in the next frame.
- rst_n pulsed low mid-ACTIVE -> the next cycle has de=vs=data=0. After release with en=1, a complete frame starting with vs is produced.
